pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_seq_pkg.sv | 31 +++
 rtl/pc_next_mux.sv | 27 ++
 rtl/pc_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_pc_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Purpose : shared types and constants for the PC sequencer (state encoding,
//           next-PC select codes, exception vectors).
// Latency : n/a (package).  Backpressure: n/a.
// Ports   : none.  Optional feature macro used by the sequencer: PC_IRQ_EN.
package pc_seq_pkg;

   // Sequencer states; encodings 6-7 are illegal and recover to FETCH.
   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd5
   } state_e;

   // Next-PC source select driven into pc_next_mux.
   typedef enum logic [2:0] {
      SEL_HOLD = 3'd0,
      SEL_INC  = 3'd1,
      SEL_BR   = 3'd2,
      SEL_J    = 3'd3,
      SEL_JR   = 3'd4
   } pc_sel_e;

   localparam logic [31:0] RESET_VEC = 32'h0000_0000;
   localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
   localparam logic [31:0] XADR_VEC  = 32'h8000_0008;
   localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/pc_next_mux.sv
// Purpose : combinational next-PC selector (hold, +4, branch, jump, jump-register).
// Latency : 0 cycles, purely combinational.  Backpressure: none.
// Ports   : i_sel select code; i_pc_cur current PC; i_br_target/i_j_target/
//           i_jr_target candidate PCs; o_pc_next selected next PC.
module pc_next_mux
   import pc_seq_pkg::*;
(
   input  pc_sel_e     i_sel,
   input  logic [31:0] i_pc_cur,
   input  logic [31:0] i_br_target,
   input  logic [31:0] i_j_target,
   input  logic [31:0] i_jr_target,
   output logic [31:0] o_pc_next
);

   always_comb begin
      o_pc_next = i_pc_cur;
      case (i_sel)
         SEL_INC: o_pc_next = i_pc_cur + PC_STEP;   // wraps mod 2^32
         SEL_BR:  o_pc_next = i_br_target;
         SEL_J:   o_pc_next = i_j_target;
         SEL_JR:  o_pc_next = i_jr_target;
         default: o_pc_next = i_pc_cur;
      endcase
   end

endmodule

// File: rtl/pc_sequencer.sv
// Purpose : multi-cycle instruction sequencer driving the PC register D input,
//           vector selects and IR/RF/memory strobes.  Optional macro PC_IRQ_EN
//           enables interrupt traps from FETCH (disabled: irq ignored, xadr 0).
// Latency : strobes and pc_next are combinational from state; epc and captured
//           decode flags are registered.  Backpressure: imem_ready/dmem_ready
//           stall FETCH/MEM while holding the PC.
// Ports   : clk, reset (async, active-high); pc_cur, imem_ready, dmem_ready;
//           dec_* decode flags; br_cond, br/j/jr targets, irq; outputs pc_next,
//           illop, xadr, ir_write, rf_write, mem_access, epc, state.
module pc_sequencer
   import pc_seq_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_cur,
   input  logic        imem_ready,
   input  logic        dmem_ready,
   input  logic        dec_illegal,
   input  logic        dec_branch,
   input  logic        dec_jump,
   input  logic        dec_jr,
   input  logic        dec_mem,
   input  logic        dec_wb,
   input  logic        br_cond,
   input  logic [31:0] br_target,
   input  logic [31:0] j_target,
   input  logic [31:0] jr_target,
   input  logic        irq,
   output logic [31:0] pc_next,
   output logic        illop,
   output logic        xadr,
   output logic        ir_write,
   output logic        rf_write,
   output logic        mem_access,
   output logic [31:0] epc,
   output logic [2:0]  state
);

   state_e      r_state;
   state_e      w_next_state;
   logic [31:0] r_epc;
   logic        r_dec_branch;
   logic        r_dec_jump;
   logic        r_dec_jr;
   logic        r_dec_mem;
   logic        r_dec_wb;

   pc_sel_e     w_sel;
   pc_sel_e     w_sel_eff;
   logic        w_irq_take;
   logic        w_epc_load;
   logic        w_capture;
   logic        w_ir_write;
   logic        w_rf_write;
   logic        w_mem_access;
   logic        w_illop;
   logic        w_xadr;

   // Interrupts are only taken from user space (pc_cur[31]=0); kernel code
   // in the upper half runs uninterruptible.
`ifdef PC_IRQ_EN
   assign w_irq_take = irq & ~pc_cur[31];
`else
   logic w_irq_unused;
   assign w_irq_unused = irq;
   assign w_irq_take   = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= FETCH;
         r_epc        <= RESET_VEC;
         r_dec_branch <= 1'b0;
         r_dec_jump   <= 1'b0;
         r_dec_jr     <= 1'b0;
         r_dec_mem    <= 1'b0;
         r_dec_wb     <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (w_epc_load) begin
            r_epc <= pc_cur;
         end
         // DECODE always lasts one cycle, so capturing while in DECODE is
         // capturing at DECODE exit.
         if (w_capture) begin
            r_dec_branch <= dec_branch;
            r_dec_jump   <= dec_jump;
            r_dec_jr     <= dec_jr;
            r_dec_mem    <= dec_mem;
            r_dec_wb     <= dec_wb;
         end
      end
   end

   always_comb begin
      w_next_state = FETCH;
      w_sel        = SEL_HOLD;
      w_ir_write   = 1'b0;
      w_rf_write   = 1'b0;
      w_mem_access = 1'b0;
      w_illop      = 1'b0;
      w_xadr       = 1'b0;
      w_epc_load   = 1'b0;
      w_capture    = 1'b0;
      case (r_state)
         FETCH: begin
            // Interrupt wins over a completing fetch; PC holds while the
            // register loads the vector via xadr.
            if (w_irq_take) begin
               w_xadr       = 1'b1;
               w_epc_load   = 1'b1;
               w_next_state = TRAP;
            end else if (imem_ready) begin
               w_ir_write   = 1'b1;
               w_sel        = SEL_INC;
               w_next_state = DECODE;
            end else begin
               w_next_state = FETCH;
            end
         end
         DECODE: begin
            w_capture = 1'b1;
            if (dec_illegal) begin
               w_illop      = 1'b1;
               w_epc_load   = 1'b1;
               w_next_state = TRAP;
            end else begin
               w_next_state = EXEC;
            end
         end
         EXEC: begin
            if (r_dec_jr) begin
               w_sel = SEL_JR;
            end else if (r_dec_jump) begin
               w_sel = SEL_J;
            end else if (r_dec_branch && br_cond) begin
               w_sel = SEL_BR;
            end
            if (r_dec_mem) begin
               w_next_state = MEM;
            end else if (r_dec_wb) begin
               w_next_state = WB;
            end else begin
               w_next_state = FETCH;
            end
         end
         MEM: begin
            w_mem_access = 1'b1;
            if (!dmem_ready) begin
               w_next_state = MEM;
            end else if (r_dec_wb) begin
               w_next_state = WB;
            end else begin
               w_next_state = FETCH;
            end
         end
         WB: begin
            w_rf_write   = 1'b1;
            w_next_state = FETCH;
         end
         TRAP: begin
            w_next_state = FETCH;
         end
         default: begin
            w_next_state = FETCH;
         end
      endcase
   end

   // Reset silences every strobe and forces a PC hold regardless of state.
   assign w_sel_eff = reset ? SEL_HOLD : w_sel;

   pc_next_mux u_pc_next_mux (
      .i_sel       (w_sel_eff),
      .i_pc_cur    (pc_cur),
      .i_br_target (br_target),
      .i_j_target  (j_target),
      .i_jr_target (jr_target),
      .o_pc_next   (pc_next)
   );

   assign ir_write   = w_ir_write   & ~reset;
   assign rf_write   = w_rf_write   & ~reset;
   assign mem_access = w_mem_access & ~reset;
   assign illop      = w_illop      & ~reset;
   assign xadr       = w_xadr       & ~reset;
   assign epc        = r_epc;
   assign state      = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Purpose : directed self-checking bench for pc_sequencer.
// Latency : n/a.  Backpressure: exercises imem/dmem stalls.
// Ports   : none (top-level bench); honours PC_IRQ_EN like the design.
module tb_pc_sequencer;

   logic        clk;
   logic        reset;
   logic [31:0] pc_cur;
   logic        imem_ready;
   logic        dmem_ready;
   logic        dec_illegal;
   logic        dec_branch;
   logic        dec_jump;
   logic        dec_jr;
   logic        dec_mem;
   logic        dec_wb;
   logic        br_cond;
   logic [31:0] br_target;
   logic [31:0] j_target;
   logic [31:0] jr_target;
   logic        irq;
   logic [31:0] pc_next;
   logic        illop;
   logic        xadr;
   logic        ir_write;
   logic        rf_write;
   logic        mem_access;
   logic [31:0] epc;
   logic [2:0]  state;

   int total = 0;
   int bad   = 0;

   pc_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .pc_cur      (pc_cur),
      .imem_ready  (imem_ready),
      .dmem_ready  (dmem_ready),
      .dec_illegal (dec_illegal),
      .dec_branch  (dec_branch),
      .dec_jump    (dec_jump),
      .dec_jr      (dec_jr),
      .dec_mem     (dec_mem),
      .dec_wb      (dec_wb),
      .br_cond     (br_cond),
      .br_target   (br_target),
      .j_target    (j_target),
      .jr_target   (jr_target),
      .irq         (irq),
      .pc_next     (pc_next),
      .illop       (illop),
      .xadr        (xadr),
      .ir_write    (ir_write),
      .rf_write    (rf_write),
      .mem_access  (mem_access),
      .epc         (epc),
      .state       (state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      imem_ready  = 1'b0;
      dmem_ready  = 1'b0;
      dec_illegal = 1'b0;
      dec_branch  = 1'b0;
      dec_jump    = 1'b0;
      dec_jr      = 1'b0;
      dec_mem     = 1'b0;
      dec_wb      = 1'b0;
      br_cond     = 1'b0;
      br_target   = 32'h0000_0040;
      j_target    = 32'h0000_0800;
      jr_target   = 32'h0000_0C00;
      irq         = 1'b0;
   endtask

   // From FETCH, complete a fetch and land in DECODE with decode inputs cleared.
   task automatic go_decode(input logic [31:0] pc);
      clear_inputs();
      pc_cur     = pc;
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset      = 1'b1;
      clear_inputs();
      pc_cur     = 32'h0000_0050;
      imem_ready = 1'b1;
      dec_illegal = 1'b1;
      repeat (2) tick();
      total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
      total++; if (epc !== 32'h0) begin bad++; $display("FAIL reset_epc got=%h exp=00000000", epc); end
      total++; if (pc_next !== 32'h0000_0050) begin bad++; $display("FAIL reset_pc_next got=%h exp=00000050", pc_next); end
      total++; if ({ir_write, rf_write, mem_access, illop, xadr} !== 5'b0) begin
         bad++; $display("FAIL reset_strobes got=%b exp=00000", {ir_write, rf_write, mem_access, illop, xadr});
      end
   endtask

   task automatic test_first_fetch();
      clear_inputs();
      pc_cur = 32'h0;
      imem_ready = 1'b0;
      reset = 1'b0;
      #1;
      total++; if (pc_next !== 32'h0 || ir_write !== 1'b0) begin
         bad++; $display("FAIL fetch_stall got pc_next=%h ir_write=%b exp=00000000 0", pc_next, ir_write);
      end
      tick();
      total++; if (state !== 3'd0) begin bad++; $display("FAIL fetch_stall_state got=%0d exp=0", state); end
      imem_ready = 1'b1;
      #1;
      total++; if (pc_next !== 32'h4 || ir_write !== 1'b1) begin
         bad++; $display("FAIL first_fetch got pc_next=%h ir_write=%b exp=00000004 1", pc_next, ir_write);
      end
      tick();
      imem_ready = 1'b0;
      pc_cur = 32'h4;
      #1;
      total++; if (state !== 3'd1) begin bad++; $display("FAIL first_decode_state got=%0d exp=1", state); end
      tick();
      total++; if (state !== 3'd2 || pc_next !== 32'h4) begin
         bad++; $display("FAIL plain_exec got state=%0d pc_next=%h exp=2 00000004", state, pc_next);
      end
      tick();
      total++; if (state !== 3'd0) begin bad++; $display("FAIL plain_exec_exit got=%0d exp=0", state); end
   endtask

   task automatic test_branch();
      go_decode(32'h0000_00FC);
      dec_branch = 1'b1;
      pc_cur = 32'h0000_0100;
      tick();
      // Live decode input dropped: the captured copy must still steer EXEC.
      dec_branch = 1'b0;
      br_cond = 1'b1;
      #1;
      total++; if (state !== 3'd2 || pc_next !== 32'h0000_0040) begin
         bad++; $display("FAIL branch_taken got state=%0d pc_next=%h exp=2 00000040", state, pc_next);
      end
      br_cond = 1'b0;
      #1;
      total++; if (pc_next !== 32'h0000_0100) begin bad++; $display("FAIL branch_not_taken got=%h exp=00000100", pc_next); end
      tick();
      total++; if (state !== 3'd0) begin bad++; $display("FAIL branch_exit got=%0d exp=0", state); end
   endtask

   task automatic test_jump_priority();
      go_decode(32'h0000_0200);
      dec_jr = 1'b1; dec_jump = 1'b1; dec_branch = 1'b1; dec_wb = 1'b1;
      tick();
      br_cond = 1'b1;
      #1;
      total++; if (pc_next !== 32'h0000_0C00) begin bad++; $display("FAIL jr_priority got=%h exp=00000c00", pc_next); end
      tick();
      total++; if (state !== 3'd4 || rf_write !== 1'b1) begin
         bad++; $display("FAIL wb_cycle got state=%0d rf_write=%b exp=4 1", state, rf_write);
      end
      tick();
      total++; if (state !== 3'd0 || rf_write !== 1'b0) begin
         bad++; $display("FAIL wb_single got state=%0d rf_write=%b exp=0 0", state, rf_write);
      end
      go_decode(32'h0000_0200);
      dec_jump = 1'b1; dec_branch = 1'b1;
      tick();
      br_cond = 1'b1;
      #1;
      total++; if (pc_next !== 32'h0000_0800) begin bad++; $display("FAIL jump_over_branch got=%h exp=00000800", pc_next); end
      tick();
   endtask

   task automatic test_illegal();
      go_decode(32'h0000_0200);
      pc_cur = 32'h0000_0204;
      dec_illegal = 1'b1;
      #1;
      total++; if (illop !== 1'b1 || xadr !== 1'b0) begin
         bad++; $display("FAIL illop_pulse got illop=%b xadr=%b exp=1 0", illop, xadr);
      end
      tick();
      dec_illegal = 1'b0;
      pc_cur = 32'h8000_0004;
      #1;
      total++; if (state !== 3'd5 || illop !== 1'b0 || epc !== 32'h0000_0204 || pc_next !== 32'h8000_0004) begin
         bad++; $display("FAIL trap_cycle got state=%0d illop=%b epc=%h pc_next=%h exp=5 0 00000204 80000004",
                         state, illop, epc, pc_next);
      end
      tick();
      total++; if (state !== 3'd0) begin bad++; $display("FAIL trap_exit got=%0d exp=0", state); end
   endtask

   task automatic test_irq();
      clear_inputs();
      pc_cur = 32'h0000_0300;
      irq = 1'b1;
      imem_ready = 1'b1;
      #1;
`ifdef PC_IRQ_EN
      total++; if (xadr !== 1'b1 || ir_write !== 1'b0 || illop !== 1'b0 || pc_next !== 32'h0000_0300) begin
         bad++; $display("FAIL irq_take got xadr=%b ir_write=%b illop=%b pc_next=%h exp=1 0 0 00000300",
                         xadr, ir_write, illop, pc_next);
      end
      tick();
      irq = 1'b0;
      imem_ready = 1'b0;
      pc_cur = 32'h8000_0008;
      #1;
      total++; if (state !== 3'd5 || epc !== 32'h0000_0300 || xadr !== 1'b0) begin
         bad++; $display("FAIL irq_trap got state=%0d epc=%h xadr=%b exp=5 00000300 0", state, epc, xadr);
      end
      tick();
      pc_cur = 32'h8000_0010;
      irq = 1'b1;
      imem_ready = 1'b1;
      #1;
      total++; if (xadr !== 1'b0 || ir_write !== 1'b1 || pc_next !== 32'h8000_0014) begin
         bad++; $display("FAIL irq_kernel got xadr=%b ir_write=%b pc_next=%h exp=0 1 80000014", xadr, ir_write, pc_next);
      end
`else
      total++; if (xadr !== 1'b0 || ir_write !== 1'b1 || pc_next !== 32'h0000_0304) begin
         bad++; $display("FAIL irq_ignored got xadr=%b ir_write=%b pc_next=%h exp=0 1 00000304", xadr, ir_write, pc_next);
      end
`endif
      tick();
      irq = 1'b0;
      imem_ready = 1'b0;
      #1;
      total++; if (state !== 3'd1) begin bad++; $display("FAIL irq_after_state got=%0d exp=1", state); end
      // Walk the empty instruction back to FETCH.
      tick();
      tick();
   endtask

   task automatic test_mem_stall();
      go_decode(32'h0000_04FC);
      dec_mem = 1'b1; dec_wb = 1'b1;
      tick();
      clear_inputs();
      pc_cur = 32'h0000_0500;
      tick();
      for (int i = 0; i < 4; i++) begin
         dmem_ready = (i == 3);
         #1;
         total++; if (state !== 3'd3 || mem_access !== 1'b1 || pc_next !== 32'h0000_0500) begin
            bad++; $display("FAIL mem_stall[%0d] got state=%0d mem_access=%b pc_next=%h exp=3 1 00000500",
                            i, state, mem_access, pc_next);
         end
         tick();
      end
      dmem_ready = 1'b0;
      total++; if (state !== 3'd4 || mem_access !== 1'b0) begin
         bad++; $display("FAIL mem_exit got state=%0d mem_access=%b exp=4 0", state, mem_access);
      end
      tick();
      // Second pass: reset lands in the middle of the stall.
      go_decode(32'h0000_04FC);
      dec_mem = 1'b1; dec_wb = 1'b1;
      tick();
      clear_inputs();
      pc_cur = 32'h0000_0500;
      tick();
      total++; if (state !== 3'd3 || mem_access !== 1'b1) begin
         bad++; $display("FAIL mem_stall2 got state=%0d mem_access=%b exp=3 1", state, mem_access);
      end
      tick();
      reset = 1'b1;
      #1;
      total++; if (state !== 3'd0 || mem_access !== 1'b0 || pc_next !== 32'h0000_0500) begin
         bad++; $display("FAIL mem_reset got state=%0d mem_access=%b pc_next=%h exp=0 0 00000500",
                         state, mem_access, pc_next);
      end
      tick();
      reset = 1'b0;
      imem_ready = 1'b1;
      #1;
      total++; if (state !== 3'd0 || ir_write !== 1'b1 || epc !== 32'h0) begin
         bad++; $display("FAIL mem_reset_release got state=%0d ir_write=%b epc=%h exp=0 1 00000000", state, ir_write, epc);
      end
      tick();
      imem_ready = 1'b0;
      // Captured flags were cleared by reset: EXEC must fall straight to FETCH.
      tick();
      tick();
      total++; if (state !== 3'd0) begin bad++; $display("FAIL flags_cleared got=%0d exp=0", state); end
   endtask

   task automatic test_wrap();
      clear_inputs();
      pc_cur = 32'hFFFF_FFFC;
      imem_ready = 1'b1;
      #1;
      total++; if (pc_next !== 32'h0000_0000 || ir_write !== 1'b1) begin
         bad++; $display("FAIL pc_wrap got pc_next=%h ir_write=%b exp=00000000 1", pc_next, ir_write);
      end
      tick();
      imem_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      pc_cur = 32'h0;
      clear_inputs();
      test_reset();
      test_first_fetch();
      test_branch();
      test_jump_priority();
      test_illegal();
      test_irq();
      test_mem_stall();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog expired got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
